// File: rtl/wb_mac_pkg.sv
// Shared register map, field positions and sequencer state encoding for wb_mac_seq.
package wb_mac_pkg;

  // Word offsets inside the 256-byte Wishbone window
  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_ACC    = 8'h08;
  localparam logic [7:0] OFF_ABUF   = 8'h40;
  localparam logic [7:0] OFF_BBUF   = 8'h80;

  // CTRL fields
  localparam int CTRL_START   = 0;
  localparam int CTRL_CLR     = 1;
  localparam int CTRL_IRQ_EN  = 2;
  localparam int CTRL_LEN_LSB = 8;
  localparam int CTRL_LEN_MSB = 12;
  localparam int LEN_W        = CTRL_LEN_MSB - CTRL_LEN_LSB + 1;

  // STATUS fields
  localparam int ST_BUSY  = 0;
  localparam int ST_DONE  = 1;
  localparam int ST_ERR   = 2;
  localparam int ST_WBUSY = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/wb_mac_if.sv
// Wishbone slave bus bundle as routed in from the user project wrapper.
interface wb_mac_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_mac_seq_mac_unit.sv
// Signed multiply-accumulate datapath: one product per enabled cycle, wrapping accumulator.
module mac_unit #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic        [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod;
  logic        [ACC_W-1:0]    prod_ext;

  assign prod     = a * b;
  // Size cast of a signed value sign-extends the full-width product
  assign prod_ext = ACC_W'(prod);

  // Accumulator: clear has priority, otherwise add the product when enabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod_ext;
    end
  end

endmodule

// File: rtl/wb_mac_seq.sv
// Wishbone-mapped dot-product sequencer: operand buffers, CSRs, run FSM and MAC datapath.
module wb_mac_seq
  import wb_mac_pkg::*;
#(
  parameter int          DATA_W    = 8,
  parameter int          ACC_W     = 32,
  parameter int          DEPTH     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  wb_mac_if.slave          bus,
  output logic [ACC_W-1:0] acc_o,
  output logic             busy_o,
  output logic             irq_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                     hit;
  logic                     req;
  logic                     wr;
  logic [7:0]               off;
  logic                     buf_ok;
  logic [IDX_W-1:0]         buf_idx;
  logic                     is_ctrl;
  logic                     is_status;
  logic                     is_acc;
  logic                     is_a;
  logic                     is_b;

  logic signed [DATA_W-1:0] a_buf [DEPTH];
  logic signed [DATA_W-1:0] b_buf [DEPTH];

  logic                     irq_en;
  logic [LEN_W-1:0]         len;
  logic                     start_pulse;

  seq_state_t               state;
  logic [IDX_W-1:0]         idx;
  logic                     done;
  logic                     err;
  logic                     wbusy;

  logic                     running;
  logic                     wr_ctrl;
  logic                     wr_status;
  logic                     wr_a;
  logic                     wr_b;
  logic                     start_req;
  logic                     clr_req;
  logic                     wbusy_set;
  logic [2:0]               w1c;
  logic                     bad_len;
  logic                     last;
  logic                     done_set;
  logic                     err_set;
  logic [31:0]              rd_data;
  logic                     unused_ok;

  // An access is serviced once, on the cycle before its ack; the ack cycle itself is not a new request
  assign hit = bus.wbs_cyc_i & bus.wbs_stb_i & (bus.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign req = hit & ~bus.wbs_ack_o;
  assign wr  = req & bus.wbs_we_i;
  assign off = bus.wbs_adr_i[7:0];

  assign buf_ok    = (int'(off[5:2]) < DEPTH);
  assign buf_idx   = IDX_W'(off[5:2]);
  assign is_ctrl   = (off[7:2] == OFF_CTRL[7:2]);
  assign is_status = (off[7:2] == OFF_STATUS[7:2]);
  assign is_acc    = (off[7:2] == OFF_ACC[7:2]);
  assign is_a      = (off[7:6] == OFF_ABUF[7:6]) & buf_ok;
  assign is_b      = (off[7:6] == OFF_BBUF[7:6]) & buf_ok;

  // Only the RUN state locks out operand/CTRL changes; FIN already reports not-busy
  assign running   = (state == S_RUN);
  assign wr_ctrl   = wr & is_ctrl;
  assign wr_status = wr & is_status;
  assign wr_a      = wr & is_a;
  assign wr_b      = wr & is_b;
  assign start_req = wr_ctrl & ~running & bus.wbs_dat_i[CTRL_START];
  assign clr_req   = wr_ctrl & ~running & bus.wbs_dat_i[CTRL_CLR];
  assign wbusy_set = running & (wr_ctrl | wr_a | wr_b);
  assign w1c       = wr_status ? bus.wbs_dat_i[ST_WBUSY:ST_DONE] : 3'b000;

  assign bad_len  = (len == '0) || (int'(len) > DEPTH);
  assign last     = (LEN_W'(idx) == (len - LEN_W'(1)));
  assign done_set = running & last;
  assign err_set  = (state == S_IDLE) & start_pulse & bad_len;

  assign irq_o = done & irq_en;

  // Select sel, byte lanes and dat bits outside the decoded fields are don't-care
  assign unused_ok = ^{bus.wbs_sel_i, bus.wbs_adr_i[1:0], bus.wbs_dat_i};

  // Read mux: CSRs, sign-extended accumulator and operands; unmapped offsets read 0
  always_comb begin
    rd_data = '0;
    if (is_ctrl) begin
      rd_data[CTRL_IRQ_EN]                = irq_en;
      rd_data[CTRL_LEN_MSB:CTRL_LEN_LSB]  = len;
    end else if (is_status) begin
      rd_data[ST_BUSY]  = busy_o;
      rd_data[ST_DONE]  = done;
      rd_data[ST_ERR]   = err;
      rd_data[ST_WBUSY] = wbusy;
    end else if (is_acc) begin
      rd_data = 32'(signed'(acc_o));
    end else if (is_a) begin
      rd_data = 32'(a_buf[buf_idx]);
    end else if (is_b) begin
      rd_data = 32'(b_buf[buf_idx]);
    end
  end

  // Bus side: single-pulse ack, registered read data, CTRL fields and the start pulse to the FSM
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      bus.wbs_ack_o <= 1'b0;
      bus.wbs_dat_o <= '0;
      irq_en        <= 1'b0;
      len           <= '0;
      start_pulse   <= 1'b0;
    end else begin
      bus.wbs_ack_o <= req;
      bus.wbs_dat_o <= (req && !bus.wbs_we_i) ? rd_data : '0;
      start_pulse   <= start_req;
      if (wr_ctrl) begin
        irq_en <= bus.wbs_dat_i[CTRL_IRQ_EN];
        if (!running) begin
          len <= bus.wbs_dat_i[CTRL_LEN_MSB:CTRL_LEN_LSB];
        end
      end
    end
  end

  // Operand buffers hold whatever was last written; they are deliberately not reset
  always_ff @(posedge wb_clk_i) begin
    if (wr_a && !running) begin
      a_buf[buf_idx] <= bus.wbs_dat_i[DATA_W-1:0];
    end
    if (wr_b && !running) begin
      b_buf[buf_idx] <= bus.wbs_dat_i[DATA_W-1:0];
    end
  end

  // Sequencer FSM with sticky status flags; a set in the same cycle as a W1C wins
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state  <= S_IDLE;
      idx    <= '0;
      busy_o <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      wbusy  <= 1'b0;
    end else begin
      done  <= (done  & ~w1c[0]) | done_set;
      err   <= (err   & ~w1c[1]) | err_set;
      wbusy <= (wbusy & ~w1c[2]) | wbusy_set;
      case (state)
        S_IDLE: begin
          if (start_pulse && !bad_len) begin
            state  <= S_RUN;
            idx    <= '0;
            busy_o <= 1'b1;
          end
        end
        S_RUN: begin
          if (last) begin
            state  <= S_FIN;
            busy_o <= 1'b0;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .clr (clr_req),
    .en  (running),
    .a   (a_buf[idx]),
    .b   (b_buf[idx]),
    .acc (acc_o)
  );

endmodule

// File: tb/tb_wb_mac_seq.sv
// Directed plus randomized bench for wb_mac_seq against a plain-arithmetic dot-product model.
module tb_wb_mac_seq;
  import wb_mac_pkg::*;

  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h00;
  localparam logic [31:0] A_STAT = BASE + 32'h04;
  localparam logic [31:0] A_ACC  = BASE + 32'h08;
  localparam logic [31:0] A_ABUF = BASE + 32'h40;
  localparam logic [31:0] A_BBUF = BASE + 32'h80;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] acc;
  logic        busy;
  logic        irq;

  wb_mac_if bus();

  wb_mac_seq dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus),
    .acc_o    (acc),
    .busy_o   (busy),
    .irq_o    (irq)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  int          a_m [16];
  int          b_m [16];
  logic [31:0] acc_m;
  logic [31:0] rdat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wb_cycle(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                          output logic [31:0] rd);
    logic got;
    @(posedge clk); #1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_sel_i = 4'hf;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = wdat;
    got = 1'b0;
    rd  = '0;
    for (int k = 0; k < 16 && !got; k++) begin
      @(posedge clk); #1;
      if (bus.wbs_ack_o) begin
        got = 1'b1;
        rd  = bus.wbs_dat_o;
      end
    end
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    check("ack_seen", {31'b0, got}, 32'd1);
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] d);
    logic [31:0] dummy;
    wb_cycle(adr, 1'b1, d, dummy);
  endtask

  task automatic rd_check(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] d;
    wb_cycle(adr, 1'b0, 32'h0, d);
    check(tag, d, exp);
  endtask

  // Dot product of the first len model elements, reduced to 32 bits
  function automatic logic [31:0] dot(input int len);
    int sum = 0;
    for (int i = 0; i < len; i++) sum += a_m[i] * b_m[i];
    return 32'(sum);
  endfunction

  task automatic load_vec(input int len);
    for (int i = 0; i < len; i++) begin
      a_m[i] = int'($urandom_range(0, 255)) - 128;
      b_m[i] = int'($urandom_range(0, 255)) - 128;
      wr(A_ABUF + 32'(4 * i), 32'(a_m[i]));
      wr(A_BBUF + 32'(4 * i), 32'(b_m[i]));
    end
  endtask

  // Issue a CTRL write with START and measure how long busy_o stays high
  task automatic run(input string tag, input logic [31:0] ctrl, input int len);
    int cnt;
    wr(A_CTRL, ctrl);
    check({tag, "_busy_at_ack"}, {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_busy_rise"}, {31'b0, busy}, 32'd1);
    cnt = busy ? 1 : 0;
    for (int k = 0; k < 40 && busy; k++) begin
      @(posedge clk); #1;
      if (busy) cnt++;
    end
    check({tag, "_busy_cycles"}, 32'(cnt), 32'(len));
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          rose;
    int          acks;
    int          len;
    int          clr;
    logic [31:0] acc_keep;

    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = '0;
    bus.wbs_dat_i = '0;
    acc_m = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack",  {31'b0, bus.wbs_ack_o}, 32'd0);
    check("rst_dat",  bus.wbs_dat_o, 32'd0);
    check("rst_acc",  acc, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_irq",  {31'b0, irq}, 32'd0);
    rst = 1'b0;
    rd_check("rst_ctrl",   A_CTRL, 32'd0);
    rd_check("rst_status", A_STAT, 32'd0);

    // Basic dot product
    a_m[0] = 1; a_m[1] = 2; a_m[2] = 3; a_m[3] = 4;
    b_m[0] = 5; b_m[1] = 6; b_m[2] = 7; b_m[3] = 8;
    for (int i = 0; i < 4; i++) begin
      wr(A_ABUF + 32'(4 * i), 32'(a_m[i]));
      wr(A_BBUF + 32'(4 * i), 32'(b_m[i]));
    end
    run("basic", 32'h0000_0403, 4);
    acc_m = dot(4);
    check("basic_acc", acc, acc_m);
    check("basic_acc_70", acc, 32'd70);
    rd_check("basic_status", A_STAT, 32'h2);
    rd_check("basic_acc_rd", A_ACC, acc_m);

    // Accumulate without CLR, interrupt enabled
    wr(A_STAT, 32'h2);
    check("accum_irq_pre", {31'b0, irq}, 32'd0);
    run("accum", 32'h0000_0405, 4);
    acc_m = acc_m + dot(4);
    check("accum_irq", {31'b0, irq}, 32'd1);
    check("accum_acc", acc, acc_m);
    check("accum_acc_140", acc, 32'd140);
    wr(A_STAT, 32'h2);
    check("accum_irq_w1c", {31'b0, irq}, 32'd0);
    rd_check("accum_ctrl", A_CTRL, 32'h0000_0404);

    // Signed extremes
    a_m[0] = -128; b_m[0] = -128;
    wr(A_ABUF, 32'(a_m[0]));
    wr(A_BBUF, 32'(b_m[0]));
    run("sgn1", 32'h0000_0103, 1);
    acc_m = dot(1);
    check("sgn1_acc", acc, acc_m);
    rd_check("sgn1_a_sext", A_ABUF, 32'hFFFF_FF80);
    wr(A_CTRL, 32'h0000_0102);
    acc_m = '0;
    check("sgn2_clr", acc, acc_m);
    a_m[0] = 127; b_m[0] = -128;
    wr(A_ABUF, 32'(a_m[0]));
    wr(A_BBUF, 32'(b_m[0]));
    run("sgn2", 32'h0000_0101, 1);
    acc_m = acc_m + dot(1);
    check("sgn2_acc", acc, acc_m);
    rd_check("sgn2_acc_rd", A_ACC, 32'hFFFF_C080);

    // Bad LEN values: ERR, no run, accumulator untouched
    wr(A_STAT, 32'hE);
    for (int t = 0; t < 2; t++) begin
      len = (t == 0) ? 0 : 17;
      wr(A_CTRL, 32'(len << 8) | 32'h1);
      rose = 0;
      for (int k = 0; k < 6; k++) begin
        @(posedge clk); #1;
        if (busy) rose = 1;
      end
      check("err_no_busy", 32'(rose), 32'd0);
      rd_check("err_status", A_STAT, 32'h4);
      check("err_acc", acc, acc_m);
      wr(A_STAT, 32'h4);
      rd_check("err_cleared", A_STAT, 32'h0);
    end

    // Randomized runs
    for (int r = 0; r < 4; r++) begin
      len = int'($urandom_range(1, 16));
      clr = int'($urandom_range(0, 1));
      load_vec(len);
      if (clr != 0) acc_m = '0;
      run("rand", 32'(len << 8) | 32'(clr << 1) | 32'h1, len);
      acc_m = acc_m + dot(len);
      check("rand_acc", acc, acc_m);
      rd_check("rand_acc_rd", A_ACC, acc_m);
      rd_check("rand_b0", A_BBUF, 32'(b_m[0]));
      wr(A_STAT, 32'h2);
    end

    // Buffer write while busy is dropped and flagged
    load_vec(16);
    acc_m = '0;
    wr(A_CTRL, 32'h0000_1003);
    wr(A_ABUF, 32'd9);
    check("wbusy_mid_run", {31'b0, busy}, 32'd1);
    for (int k = 0; k < 40 && busy; k++) begin
      @(posedge clk); #1;
    end
    check("wbusy_run_end", {31'b0, busy}, 32'd0);
    acc_m = dot(16);
    check("wbusy_acc", acc, acc_m);
    rd_check("wbusy_status", A_STAT, 32'hA);
    rd_check("wbusy_a0", A_ABUF, 32'(a_m[0]));

    // Asynchronous reset mid-run
    wr(A_CTRL, 32'h0000_1001);
    repeat (3) @(posedge clk);
    #1;
    check("rstrun_busy_pre", {31'b0, busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rstrun_busy", {31'b0, busy}, 32'd0);
    check("rstrun_acc",  acc, 32'd0);
    check("rstrun_irq",  {31'b0, irq}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    acc_m = '0;
    rd_check("rstrun_status", A_STAT, 32'h0);
    rd_check("rstrun_ctrl",   A_CTRL, 32'h0);
    rd_check("rstrun_acc_rd", A_ACC,  acc_m);

    // Out-of-window access is never acked
    @(posedge clk); #1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_adr_i = 32'h3000_0100;
    acks = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (bus.wbs_ack_o) acks++;
    end
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    check("decode_no_ack", 32'(acks), 32'd0);

    // Unmapped in-window offset: acked, reads 0, write dropped
    wr(BASE + 32'h0C, 32'hDEAD_BEEF);
    rd_check("unmapped_rd", BASE + 32'h0C, 32'h0);
    acc_keep = acc;
    check("unmapped_acc", acc_keep, acc_m);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
